// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the five-digit segment scan controller.
package seg_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SHOW = 2'd2,
      BLNK = 2'd3
   } state_e;

   localparam int unsigned DWELL_DEFAULT = 16;
   localparam int unsigned BLANK_DEFAULT = 2;
   localparam logic [7:0]  BLANK_CODE    = 8'h00;

   // One-hot digit enable for digit index 0..4; out-of-range gives no digit.
   function automatic logic [4:0] onehot5(input logic [2:0] idx);
      logic [4:0] oh;
      oh = 5'b00000;
      unique case (idx)
         3'd0:    oh = 5'b00001;
         3'd1:    oh = 5'b00010;
         3'd2:    oh = 5'b00100;
         3'd3:    oh = 5'b01000;
         3'd4:    oh = 5'b10000;
         default: oh = 5'b00000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Up-counting slot timer shared by the SHOW and BLNK slots.
// load_i restarts the count at 0; last_o flags the final cycle of a slot of len_i cycles.
module scan_slot_timer (
   input  logic       ck,
   input  logic       rs,
   input  logic       load_i,
   input  logic [7:0] len_i,
   output logic [7:0] t_next_o,
   output logic       last_o
);

   logic [7:0] t_q, t_d;

   // Next count: restart on load, otherwise advance.
   always_comb begin
      t_d = load_i ? 8'd0 : t_q + 8'd1;
   end

   // Count register with synchronous reset.
   always_ff @(posedge ck) begin
      if (rs) t_q <= 8'd0;
      else    t_q <= t_d;
   end

   assign t_next_o = t_d;
   assign last_o   = (t_q == len_i - 8'd1);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes five 8-bit segment codes onto one bus with per-frame brightness (PWM on-time).
// Outputs are decoded from next-state values and registered, so they line up with the state.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int unsigned DWELL = DWELL_DEFAULT,
   parameter int unsigned BLANK = BLANK_DEFAULT
) (
   input  logic       ck,
   input  logic       rs,
   input  logic       en,
   input  logic [2:0] bright,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [7:0] C,
   input  logic [7:0] D,
   input  logic [7:0] E,
   output logic [7:0] seg,
   output logic [4:0] dig,
   output logic       frame
);

   localparam logic [7:0] DwellLen = 8'(DWELL);
   localparam logic [7:0] BlankLen = 8'(BLANK);

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [4:0][7:0] sh_q, sh_d;
   logic [2:0]      bright_q, bright_d;

   logic       tmr_load;
   logic [7:0] tmr_len;
   logic [7:0] t_next;
   logic       tmr_last;

   logic [10:0] on_d;
   logic [7:0]  cur_code;
   logic        lit;
   logic [7:0]  seg_d;
   logic [4:0]  dig_d;
   logic        frame_d;

   scan_slot_timer u_slot_timer (
      .ck       (ck),
      .rs       (rs),
      .load_i   (tmr_load),
      .len_i    (tmr_len),
      .t_next_o (t_next),
      .last_o   (tmr_last)
   );

   // Scan FSM next-state, shadow snapshot and timer control.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sh_d     = sh_q;
      bright_d = bright_q;
      tmr_load = 1'b0;
      tmr_len  = (state_q == SHOW) ? DwellLen : BlankLen;
      case (state_q)
         IDLE: begin
            tmr_load = 1'b1;
            if (en) state_d = LOAD;
         end
         LOAD: begin
            tmr_load = 1'b1;
            state_d  = SHOW;
            idx_d    = 3'd0;
            sh_d     = {E, D, C, B, A};
            bright_d = bright;
         end
         SHOW: begin
            if (tmr_last) begin
               tmr_load = 1'b1;
               state_d  = BLNK;
            end
         end
         BLNK: begin
            if (tmr_last) begin
               tmr_load = 1'b1;
               if (idx_q < 3'd4) begin
                  state_d = SHOW;
                  idx_d   = idx_q + 3'd1;
               end else if (en) begin
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the upcoming state: inline 5:1 mux, one-hot enable and PWM gate.
   always_comb begin
      on_d = ((11'(bright_d) + 11'd1) * 11'(DWELL)) >> 3;
      case (idx_d)
         3'd0:    cur_code = sh_d[0];
         3'd1:    cur_code = sh_d[1];
         3'd2:    cur_code = sh_d[2];
         3'd3:    cur_code = sh_d[3];
         3'd4:    cur_code = sh_d[4];
         default: cur_code = BLANK_CODE;
      endcase
      lit     = (state_d == SHOW) && ({3'b000, t_next} < on_d);
      dig_d   = lit ? onehot5(idx_d) : 5'b00000;
      seg_d   = lit ? cur_code : BLANK_CODE;
      frame_d = (state_d == BLNK) && (idx_d == 3'd4) && (t_next == BlankLen - 8'd1);
   end

   // State, shadow and output registers; reset overrides everything, including en.
   always_ff @(posedge ck) begin
      if (rs) begin
         state_q  <= IDLE;
         idx_q    <= 3'd0;
         sh_q     <= {5{BLANK_CODE}};
         bright_q <= 3'd0;
         seg      <= BLANK_CODE;
         dig      <= 5'b00000;
         frame    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         sh_q     <= sh_d;
         bright_q <= bright_d;
         seg      <= seg_d;
         dig      <= dig_d;
         frame    <= frame_d;
      end
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 16: clock cycles per digit SHOW slot; legal range 8..255.
REQ-002 Parameter BLANK, default 2: clock cycles per inter-digit blanking slot; legal range 1..15.
REQ-003 ck  input  1  system clock; all state changes on the rising edge.
REQ-004 rs  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  scan enable; level-sensitive.
REQ-006 bright  input  3  brightness code 0..7, sampled once per frame.
REQ-007 A,B,C,D,E  input  8 each  segment codes for digits 0..4, with bit0 = segment a and bit7 = dp.
REQ-008 seg  output  8  shared segment bus; active-high; registered.
REQ-009 dig  output  5  one-hot digit enable, active-high; dig[0]=A … dig[4]=E; registered.
REQ-010 frame  output  1  one-cycle pulse at the end of each completed frame; registered.

Function
REQ-011 The block SHALL time-multiplex the five 8-bit digit codes onto the single seg bus in the order A,B,C,D,E, with dig selecting the driven digit.
REQ-012 The FSM SHALL have four states:
- IDLE: dig=0, seg=0.
- LOAD: snapshot A..E and bright into shadow registers, and set idx=0.
- SHOW: drive the current digit.
- BLNK: dig=0, seg=0.
REQ-013 Transitions SHALL be:
- IDLE→LOAD when en=1; otherwise stay in IDLE.
- LOAD→SHOW after 1 cycle.
- SHOW→BLNK after exactly DWELL cycles.
- BLNK→SHOW with idx+1 after exactly BLANK cycles when idx<4.
- BLNK with idx==4 → LOAD if en=1, else IDLE.
REQ-014 Digit codes SHALL be snapshotted only in LOAD, so input changes mid-frame do not appear until the next frame (no tearing).
REQ-015 The on-time SHALL be ON = ((bright_shadow+1)*DWELL)>>3, computed at 11 bits unsigned and truncated toward zero.
REQ-016 In SHOW, with slot counter t = 0..DWELL-1:
- t<ON: dig=onehot(idx) and seg=shadow[idx].
- otherwise: dig=0 and seg=0.
REQ-017 dig SHALL never have more than one bit set in any cycle.
REQ-018 seg SHALL be 0 in every cycle where dig==0.
REQ-019 frame SHALL pulse high for exactly one cycle, in the last BLNK cycle of idx==4.
REQ-020 Frame period SHALL be 1 + 5*(DWELL+BLANK) cycles.
REQ-021 Deasserting en mid-frame SHALL NOT abort the frame; the current frame completes, including its frame pulse, then the FSM enters IDLE.
REQ-022 If en is deasserted and reasserted within the same frame, scanning SHALL continue with no IDLE cycle.
REQ-023 Outputs SHALL follow state with 1-cycle registered latency: the first SHOW cycle's dig/seg appear on the edge after LOAD.

Reset
REQ-024 When rs=1 at a clock edge, the block SHALL set the following, overriding en:
- state=IDLE;
- idx=0;
- slot counters=0;
- shadow registers=8'h00;
- bright shadow=0;
- seg=8'h00, dig=5'b00000, frame=0.
REQ-025 Reset asserted mid-frame SHALL blank outputs on the next edge, with no frame pulse.
REQ-026 After rs is released, the earliest LOAD SHALL be the first edge with rs=0 and en=1.

Structure
REQ-027 A shared package SHALL hold:
- the state encoding constants IDLE/LOAD/SHOW/BLNK (2-bit);
- the DWELL and BLANK defaults;
- the blank code 8'h00.
REQ-028 The slot timer (load, count, terminal flag) SHALL be one sub-module, scan_slot_timer, instantiated once and reused for both SHOW and BLNK.
REQ-029 The 5:1 segment mux and one-hot decode SHALL stay inline.

Verification
REQ-030 Basic scan: defaults, bright=7, A..E=5B,79,5E,40,77, en=1 → per digit, 16 cycles with dig=00001, seg=5B, then 2 blank cycles; continues through dig=10000, seg=77. Frame pulses every 91 cycles.
REQ-031 Dimming: bright=0 → ON=2, so each digit is lit 2 of 16 cycles. With bright=3 → ON=8. A new bright value applied mid-frame takes effect only at the next LOAD.
REQ-032 No tearing: change C from 5E to 3D during the SHOW of digit A → the current frame still shows 5E on dig=00100; the next frame shows 3D.
REQ-033 Graceful stop: drop en during the SHOW of digit B → digits C, D and E complete, frame pulses once, then IDLE with dig=0 and seg=0 held.
REQ-034 Reset mid-frame: rs=1 for 1 cycle during the SHOW of digit D, en=1 held → the next edge gives dig=0, seg=0, frame=0; LOAD follows on the edge after rs falls; the next lit digit is A.
REQ-035 Throughout all scenarios, assertion checks: onehot0(dig), and (dig==0 → seg==0).
